run_control: RTL

Run sequencer for the muon-lifetime front panel. It consumes the five debounced push-button levels and converts them to single-cycle rising-edge events. From those events it drives the acquisition state machine (IDLE/RUN/HOLD/CLEAR), sets the coincidence-window length with auto-repeat stepping, and counts recorded decays. It sits between the button debouncer and the TDC/histogram datapath, which it enables, clears and configures.

---
 rtl/run_control_if.sv | 27 ++
 rtl/run_control.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/run_control_if.sv
// Front-panel bus for the run sequencer: debounced buttons and TDC decay
// pulses in, acquisition control and status out.
interface run_control_if #(
    parameter int WIN_W   = 16,
    parameter int COUNT_W = 24
);
    logic [4:0]         btn;
    logic               decay_valid;
    logic               run_en;
    logic               clear_pulse;
    logic [WIN_W-1:0]   window;
    logic [COUNT_W-1:0] event_count;
    logic               done;
    logic [1:0]         state;

    // Panel / stimulus side
    modport master (
        output btn, decay_valid,
        input  run_en, clear_pulse, window, event_count, done, state
    );

    // Sequencer side
    modport slave (
        input  btn, decay_valid,
        output run_en, clear_pulse, window, event_count, done, state
    );
endinterface

// File: rtl/run_control.sv
// Run sequencer for the muon-lifetime front panel. Turns button levels into
// rise events, runs the IDLE/RUN/HOLD/CLEAR acquisition machine, steps the
// coincidence window with auto-repeat and counts recorded decays.
module run_control #(
    parameter int WIN_W         = 16,
    parameter int WIN_DEFAULT   = 1000,
    parameter int WIN_MIN       = 10,
    parameter int WIN_MAX       = 20000,
    parameter int WIN_STEP      = 10,
    parameter int REPEAT_DELAY  = 5,
    parameter int REPEAT_PERIOD = 2,
    parameter int COUNT_W       = 24,
    parameter int MAX_EVENTS    = 16777215
) (
    input  logic         clock,
    input  logic         reset,
    run_control_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    // Repeat counter runs 1..DELAY, then wraps between DELAY and DELAY+PERIOD
    localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_WRAP  = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD);

    // Window math carries one extra bit so stepping never wraps
    localparam logic [WIN_W:0] WX_MIN  = (WIN_W+1)'(WIN_MIN);
    localparam logic [WIN_W:0] WX_MAX  = (WIN_W+1)'(WIN_MAX);
    localparam logic [WIN_W:0] WX_STEP = (WIN_W+1)'(WIN_STEP);

    localparam logic [WIN_W-1:0]   WIN_RST = WIN_W'(WIN_DEFAULT);
    localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(MAX_EVENTS);

    function automatic logic [WIN_W-1:0] sat_up(input logic [WIN_W-1:0] w);
        logic [WIN_W:0] sum;
        sum = {1'b0, w} + WX_STEP;
        if (sum > WX_MAX) begin
            sum = WX_MAX;
        end
        return sum[WIN_W-1:0];
    endfunction

    function automatic logic [WIN_W-1:0] sat_down(input logic [WIN_W-1:0] w);
        logic [WIN_W:0] ext;
        logic [WIN_W:0] diff;
        ext  = {1'b0, w};
        diff = ext - WX_STEP;
        if (ext < WX_MIN + WX_STEP) begin
            diff = WX_MIN;
        end
        return diff[WIN_W-1:0];
    endfunction

    state_t             cur_state;
    state_t             st_nxt;
    logic [4:0]         btn_q;
    logic [4:0]         rise;
    logic               any_rise;
    logic               start_r;
    logic               clr_r;
    logic               exit_r;
    logic               up_r;
    logic               dn_r;
    logic               held;
    logic [RPT_W-1:0]   rpt_cnt;
    logic [RPT_W-1:0]   rpt_nxt;
    logic               rpt_fire;
    logic               rpt_clr;
    logic               cnt_inc;
    logic               cnt_hit;
    logic [WIN_W-1:0]   window_q;
    logic [WIN_W-1:0]   win_nxt;
    logic [COUNT_W-1:0] count_q;
    logic               done_q;
    logic               run_en_q;
    logic               clear_q;

    // Rise decode, single-action priority, auto-repeat and next-state selection
    always_comb begin
        rise     = bus.btn & ~btn_q;
        any_rise = |rise;

        // Only the highest-priority rise survives: start > clear > exit > up > down
        start_r = rise[0];
        clr_r   = rise[3] & ~rise[0];
        exit_r  = rise[4] & ~rise[3] & ~rise[0];
        up_r    = rise[1] & ~(rise[0] | rise[3] | rise[4]);
        dn_r    = rise[2] & ~rise[1] & ~(rise[0] | rise[3] | rise[4]);

        // Exactly one of up/down held is the only case that auto-repeats
        held     = bus.btn[1] ^ bus.btn[2];
        rpt_nxt  = rpt_cnt + 1'b1;
        rpt_fire = (cur_state == IDLE) && held && !any_rise &&
                   ((rpt_nxt == RPT_FIRST) || (rpt_nxt == RPT_WRAP));

        cnt_inc = (cur_state == RUN) && bus.decay_valid && (count_q != CNT_MAX);
        cnt_hit = cnt_inc && (count_q == CNT_MAX - 1'b1);

        st_nxt = cur_state;
        case (cur_state)
            IDLE: begin
                if (start_r && !done_q) begin
                    st_nxt = RUN;
                end else if (clr_r) begin
                    st_nxt = CLEAR;
                end
            end
            RUN: begin
                if (cnt_hit || start_r) begin
                    st_nxt = HOLD;
                end
            end
            HOLD: begin
                if (start_r && !done_q) begin
                    st_nxt = RUN;
                end else if (clr_r) begin
                    st_nxt = CLEAR;
                end else if (exit_r) begin
                    st_nxt = IDLE;
                end
            end
            default: st_nxt = IDLE;
        endcase

        win_nxt = window_q;
        if (cur_state == IDLE) begin
            if (up_r || (rpt_fire && bus.btn[1])) begin
                win_nxt = sat_up(window_q);
            end else if (dn_r || (rpt_fire && bus.btn[2])) begin
                win_nxt = sat_down(window_q);
            end
        end

        rpt_clr = (cur_state != IDLE) || (st_nxt != IDLE) || !held ||
                  rise[1] || rise[2];
    end

    // Previous button sample and the auto-repeat timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_q   <= '0;
            rpt_cnt <= '0;
        end else begin
            btn_q <= bus.btn;
            if (rpt_clr) begin
                rpt_cnt <= '0;
            end else if (rpt_nxt == RPT_WRAP) begin
                rpt_cnt <= RPT_FIRST;
            end else begin
                rpt_cnt <= rpt_nxt;
            end
        end
    end

    // Acquisition state machine with its registered outputs, window and counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= IDLE;
            run_en_q  <= 1'b0;
            clear_q   <= 1'b0;
            window_q  <= WIN_RST;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            cur_state <= st_nxt;
            run_en_q  <= (st_nxt == RUN);
            clear_q   <= (st_nxt == CLEAR);
            window_q  <= win_nxt;
            if (st_nxt == CLEAR && cur_state != CLEAR) begin
                count_q <= '0;
                done_q  <= 1'b0;
            end else if (cnt_inc) begin
                count_q <= count_q + 1'b1;
                if (cnt_hit) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign bus.state       = cur_state;
    assign bus.run_en      = run_en_q;
    assign bus.clear_pulse = clear_q;
    assign bus.window      = window_q;
    assign bus.event_count = count_q;
    assign bus.done        = done_q;

endmodule
